// File: rtl/ahb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter_if -- bus-side signal bundle for the AHB round-robin arbiter.
//
// Handshake: a transfer phase completes on a rising HCLK edge where
// HREADY=1. All arbiter outputs change only on such edges (or on reset).
// Requesters raise HBUSREQx (and optionally HLOCKx) and hold them until they
// see HGRANTx.
//
// Signals
//   HBUSREQx  [NUM_MASTERS] per-master bus request
//   HLOCKx    [NUM_MASTERS] per-master locked-transfer request
//   HSPLIT    [NUM_MASTERS] per-master split-resume strobe from slaves
//   HRESP     [2]           slave response, 2'b11 = SPLIT
//   HREADY                  transfer-complete strobe
//   HGRANTx   [NUM_MASTERS] one-hot grant (arbiter output)
//   HMASTER   [4]           address-phase owner index (arbiter output)
//   HMASTLOCK               current address phase is locked (arbiter output)
//
// Modports
//   slave  : the arbiter's view (requests in, grant out)
//   master : the requesting side / bench (requests out, grant in)
// ---------------------------------------------------------------------------
interface ahb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] HBUSREQx;
  logic [NUM_MASTERS-1:0] HLOCKx;
  logic [NUM_MASTERS-1:0] HSPLIT;
  logic [1:0]             HRESP;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANTx;
  logic [3:0]             HMASTER;
  logic                   HMASTLOCK;

  modport slave (
    input  HBUSREQx, HLOCKx, HSPLIT, HRESP, HREADY,
    output HGRANTx, HMASTER, HMASTLOCK
  );

  modport master (
    output HBUSREQx, HLOCKx, HSPLIT, HRESP, HREADY,
    input  HGRANTx, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter -- AHB round-robin bus arbiter with lock hold and optional
// split masking.
//
// Ports
//   HCLK    single clock, rising edge
//   HRESET  synchronous active-high reset
//   bus     ahb_rr_arbiter_if.slave (requests, HREADY, HRESP, HSPLIT in;
//           HGRANTx, HMASTER, HMASTLOCK out)
//
// Parameters
//   NUM_MASTERS    2..16 requesters
//   DEFAULT_MASTER owner when nothing eligible is requesting
//
// Build option
//   AHB_ARB_SPLIT_EN  when defined, a SPLIT response (HRESP=2'b11 on an
//                     HREADY=0 edge) masks the data-phase master until a
//                     slave pulses its HSPLIT bit. Without it HSPLIT and
//                     HRESP are ignored and no mask register exists.
//
// Behaviour
//   The grant owner index is the round-robin pointer. On each HREADY=1 edge
//   the search starts at owner+1 and wraps; the current owner is checked last
//   so a re-requesting master yields to any other eligible requester. A
//   locked, requesting, unmasked owner keeps the grant. HMASTER/HMASTLOCK
//   trail the grant by one HREADY=1 edge (address phase of the prior owner).
// ---------------------------------------------------------------------------
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_rr_arbiter_if.slave  bus
);

  localparam logic [3:0] DEF_IDX = 4'(DEFAULT_MASTER);

  logic [3:0]             r_owner;
  logic [3:0]             r_hmaster;
  logic                   r_mastlock;

  logic [NUM_MASTERS-1:0] w_mask;
  // Zero-extended to 16 bits so the 4-bit owner index can select any bit
  // without width trouble for small NUM_MASTERS.
  logic [15:0]            w_req16;
  logic [15:0]            w_lock16;
  logic [15:0]            w_mask16;
  logic [15:0]            w_elig16;
  logic                   w_hold;
  logic                   w_found;
  logic [3:0]             w_idx;
  logic [3:0]             w_next_owner;

`ifdef AHB_ARB_SPLIT_EN
  logic [NUM_MASTERS-1:0] r_mask;
  logic [NUM_MASTERS-1:0] w_mask_set;

  // SPLIT is reported during the data phase, so the victim is HMASTER.
  // DEFAULT_MASTER is never masked so the bus always has a fallback owner.
  always_comb begin
    w_mask_set = '0;
    if (bus.HRESP == 2'b11 && !bus.HREADY && r_hmaster != DEF_IDX)
      w_mask_set = NUM_MASTERS'(16'(1) << r_hmaster);
  end

  // Clear is applied after set so a coincident HSPLIT wins.
  always_ff @(posedge HCLK) begin
    if (HRESET) r_mask <= '0;
    else        r_mask <= (r_mask | w_mask_set) & ~bus.HSPLIT;
  end

  assign w_mask = r_mask;
`else
  logic w_unused_split;
  assign w_unused_split = ^{bus.HSPLIT, bus.HRESP};
  assign w_mask = '0;
`endif

  assign w_req16  = 16'(bus.HBUSREQx);
  assign w_lock16 = 16'(bus.HLOCKx);
  assign w_mask16 = 16'(w_mask);
  assign w_elig16 = w_req16 & ~w_mask16;

  // Next owner: lock hold first, otherwise rotate from owner+1; the owner
  // itself is the last candidate (k == NUM_MASTERS).
  always_comb begin
    w_hold       = w_lock16[r_owner] & w_elig16[r_owner];
    w_next_owner = DEF_IDX;
    w_found      = 1'b0;
    w_idx        = '0;
    if (w_hold) begin
      w_next_owner = r_owner;
      w_found      = 1'b1;
    end
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_idx = 4'((int'(r_owner) + k) % NUM_MASTERS);
      if (!w_found && w_elig16[w_idx]) begin
        w_next_owner = w_idx;
        w_found      = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_owner    <= DEF_IDX;
      r_hmaster  <= DEF_IDX;
      r_mastlock <= 1'b0;
    end else if (bus.HREADY) begin
      r_owner    <= w_next_owner;
      r_hmaster  <= r_owner;
      // A masked (split) owner loses its lock on the address phase.
      r_mastlock <= w_lock16[r_owner] & ~w_mask16[r_owner];
    end
  end

  // Grant is decoded from the index register, so it is one-hot by construction.
  assign bus.HGRANTx   = NUM_MASTERS'(16'(1) << r_owner);
  assign bus.HMASTER   = r_hmaster;
  assign bus.HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_rr_arbiter -- self-checking bench for ahb_rr_arbiter
// (NUM_MASTERS=4, DEFAULT_MASTER=0). Split scenarios run only when
// AHB_ARB_SPLIT_EN is defined.
// ---------------------------------------------------------------------------
module tb_ahb_rr_arbiter;
  localparam int N   = 4;
  localparam int DEF = 0;
  localparam int W   = N + 5;   // {grant, master[3:0], mastlock}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_rr_arbiter_if #(.NUM_MASTERS(N)) bus ();

  ahb_rr_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  int           m_owner = DEF;
  int           m_hm    = DEF;
  logic         m_ml    = 1'b0;
  logic [N-1:0] m_mask  = '0;

  // Eligible master with the smallest forward distance from owner+1.
  function automatic int pick(input int owner, input logic [N-1:0] elig);
    int best   = DEF;
    int best_d = N;
    for (int i = 0; i < N; i++) begin
      int d = (i - owner - 1 + 2 * N) % N;
      if (elig[i] && d < best_d) begin
        best_d = d;
        best   = i;
      end
    end
    return best;
  endfunction

  task automatic model_step();
    logic [N-1:0] elig;
    logic [N-1:0] new_mask;
    int           nxt;
    if (rst) begin
      m_owner = DEF;
      m_hm    = DEF;
      m_ml    = 1'b0;
      m_mask  = '0;
      return;
    end
    elig     = bus.HBUSREQx & ~m_mask;
    new_mask = m_mask;
`ifdef AHB_ARB_SPLIT_EN
    if (bus.HRESP == 2'b11 && !bus.HREADY && m_hm != DEF) new_mask[m_hm] = 1'b1;
    new_mask = new_mask & ~bus.HSPLIT;
`endif
    if (bus.HREADY) begin
      if (bus.HLOCKx[m_owner] && elig[m_owner]) nxt = m_owner;
      else                                       nxt = pick(m_owner, elig);
      m_ml    = bus.HLOCKx[m_owner] && !m_mask[m_owner];
      m_hm    = m_owner;
      m_owner = nxt;
    end
    m_mask = new_mask;
  endtask

  function automatic logic [W-1:0] model_exp();
    logic [N-1:0] g = '0;
    g[m_owner] = 1'b1;
    return {g, 4'(m_hm), m_ml};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic rdy, input logic [N-1:0] req,
                       input logic [N-1:0] lock, input logic [N-1:0] split,
                       input logic [1:0] resp);
    rst          = r;
    bus.HREADY   = rdy;
    bus.HBUSREQx = req;
    bus.HLOCKx   = lock;
    bus.HSPLIT   = split;
    bus.HRESP    = resp;
  endtask

  // One edge; inputs stay stable across it and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic score(input string name, input logic [W-1:0] exp);
    logic [W-1:0] got;
    logic [W-1:0] e;
    exp_q.push_back(exp);
    e   = exp_q.pop_front();
    got = {bus.HGRANTx, bus.HMASTER, bus.HMASTLOCK};
    n_checks++;
    if (got === e) n_pass++;
    else $display("FAIL %s: got grant=%b master=%0d lock=%b, expected grant=%b master=%0d lock=%b",
                  name, got[W-1:5], got[4:1], got[0], e[W-1:5], e[4:1], e[0]);
  endtask

  // Hand-written step with a hand-derived expectation.
  task automatic hs(input string name, input logic r, input logic rdy,
                    input logic [N-1:0] req, input logic [N-1:0] lock,
                    input logic [N-1:0] split, input logic [1:0] resp,
                    input logic [N-1:0] g, input int m, input logic l);
    drive(r, rdy, req, lock, split, resp);
    tick();
    score(name, {g, 4'(m), l});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic         ready;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] g;
    int           m;
    logic         l;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic rdy, input logic [N-1:0] req,
                              input logic [N-1:0] lock, input logic [N-1:0] g,
                              input int m, input logic l);
    vec_t v;
    v.rst = r; v.ready = rdy; v.req = req; v.lock = lock;
    v.g = g; v.m = m; v.l = l;
    return v;
  endfunction

  initial begin
    drive(1'b1, 1'b1, '0, '0, '0, 2'b00);

    //              rst   rdy   req      lock     grant    m  lock
    tbl.push_back(mk(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0001, 0, 1'b0)); // reset
    tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 0, 1'b0)); // idle -> default
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0010, 0, 1'b0)); // rotation
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0100, 1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1000, 2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0001, 3, 1'b0)); // wrap
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0010, 0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0100, 4'b0100, 1, 1'b0)); // 2 locks
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0100, 4'b0100, 2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0100, 4'b0100, 2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0100, 4'b0100, 2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0100, 4'b0100, 2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1000, 2, 1'b0)); // release -> 3
    tbl.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0001, 3, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0001, 3, 1'b0)); // HREADY low x3
    tbl.push_back(mk(1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0001, 3, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0001, 3, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0010, 0, 1'b0)); // update
    tbl.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0010, 1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'b0101, 4'b0000, 4'b0100, 0, 1'b0)); // 0/2 alternate
    tbl.push_back(mk(1'b0, 1'b1, 4'b0101, 4'b0000, 4'b0001, 2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'b0101, 4'b0000, 4'b0100, 0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'b1000, 4'b1000, 4'b1000, 2, 1'b0)); // 3 locks
    tbl.push_back(mk(1'b0, 1'b1, 4'b1000, 4'b1000, 4'b1000, 3, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 4'b1000, 4'b1000, 4'b0001, 0, 1'b0)); // reset mid-lock
    tbl.push_back(mk(1'b0, 1'b1, 4'b1000, 4'b1000, 4'b1000, 0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 3, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].ready, tbl[i].req, tbl[i].lock, '0, 2'b00);
      tick();
      score($sformatf("vec%0d", i), {tbl[i].g, 4'(tbl[i].m), tbl[i].l});
    end

    // Master 0 locked across an HREADY stall, then released.
    hs("lock0_take",  1'b0, 1'b1, 4'b0001, 4'b0001, '0, 2'b00, 4'b0001, 0, 1'b1);
    hs("lock0_stall", 1'b0, 1'b0, 4'b1111, 4'b0001, '0, 2'b00, 4'b0001, 0, 1'b1);
    hs("lock0_rel",   1'b0, 1'b1, 4'b1111, 4'b0000, '0, 2'b00, 4'b0010, 0, 1'b0);

`ifdef AHB_ARB_SPLIT_EN
    hs("sp_own1",     1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 2'b00, 4'b0010, 1, 1'b0);
    hs("sp_resp",     1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 2'b11, 4'b0010, 1, 1'b0);
    hs("sp_leave",    1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 2'b00, 4'b0001, 1, 1'b0);
    hs("sp_masked",   1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 2'b00, 4'b0001, 0, 1'b0);
    hs("sp_clear",    1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0010, 2'b00, 4'b0001, 0, 1'b0);
    hs("sp_regrant",  1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 2'b00, 4'b0010, 0, 1'b0);
    hs("sp_to3",      1'b0, 1'b1, 4'b1010, 4'b0000, 4'b0000, 2'b00, 4'b1000, 1, 1'b0);
    hs("sp_mask1",    1'b0, 1'b0, 4'b1010, 4'b1000, 4'b0000, 2'b11, 4'b1000, 1, 1'b0);
    hs("sp_lock3",    1'b0, 1'b1, 4'b1010, 4'b1000, 4'b0000, 2'b00, 4'b1000, 3, 1'b1);
    hs("sp_reset",    1'b1, 1'b1, 4'b1010, 4'b1000, 4'b0000, 2'b00, 4'b0001, 0, 1'b0);
    hs("sp_nomask",   1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 2'b00, 4'b0010, 0, 1'b0);
    hs("sp_def_resp", 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 2'b11, 4'b0010, 0, 1'b0);
    hs("sp_def_ok",   1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0000, 2'b00, 4'b0001, 1, 1'b0);
    hs("sp_rr1",      1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0000, 2'b00, 4'b0010, 0, 1'b0);
    hs("sp_rr0",      1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0000, 2'b00, 4'b0001, 1, 1'b0);
    hs("sp_setclr",   1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0010, 2'b11, 4'b0001, 1, 1'b0);
    hs("sp_clrwins",  1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 2'b00, 4'b0010, 0, 1'b0);
`endif

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] req;
      logic [N-1:0] lock;
      logic [N-1:0] split;
      req   = N'($urandom_range(0, (1 << N) - 1));
      lock  = N'($urandom_range(0, (1 << N) - 1)) & (($urandom_range(0, 1) == 1) ? req : '0);
      split = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 3) != 0,
            req, lock, split,
            ($urandom_range(0, 5) == 0) ? 2'b11 : 2'(($urandom_range(0, 2))));
      tick();
      score($sformatf("rand%0d", c), model_exp());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of bus masters; legal range 2..16.
REQ-002 Parameter DEFAULT_MASTER, default 0: master granted when nothing is requested; legal range 0..NUM_MASTERS-1.
REQ-003 HCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 HRESET  input  1  synchronous, active-high reset.
REQ-005 HBUSREQx  input  NUM_MASTERS  per-master bus request.
REQ-006 HLOCKx  input  NUM_MASTERS  per-master locked-transfer request.
REQ-007 HSPLIT  input  NUM_MASTERS  per-master split-resume strobe from slaves.
REQ-008 HRESP  input  2  slave response; 2'b11 = SPLIT.
REQ-009 HREADY  input  1  transfer-complete strobe.
REQ-010 HGRANTx  output  NUM_MASTERS  one-hot grant.
REQ-011 HMASTER  output  4  index of the master owning the address phase.
REQ-012 HMASTLOCK  output  1  current address phase is locked.

Function
REQ-013 HGRANTx shall be one-hot on every cycle after reset: exactly one bit high, never zero, never more than one.
REQ-014 Arbitration shall be round-robin: search starts at the index after the current grant owner, ascending modulo NUM_MASTERS; the first requesting, unmasked master wins.
REQ-015 With no eligible request, the grant shall go to DEFAULT_MASTER.
REQ-016 HGRANTx shall update only on a rising edge with HREADY=1; with HREADY=0 all outputs hold.
REQ-017 Lock hold: while the current owner has HLOCKx=1 and HBUSREQx=1, the grant shall stay with it regardless of other requests.
REQ-018 The lock is released on the first HREADY=1 edge after the owner drops HLOCKx or HBUSREQx.
REQ-019 On each rising edge with HREADY=1, HMASTER shall load the index of the master granted before that edge, giving one address-phase cycle of latency behind HGRANTx.
REQ-020 On the same edges, HMASTLOCK shall load HLOCKx of the master granted before that edge.
REQ-021 Grant owner index arithmetic shall wrap from NUM_MASTERS-1 to 0.
REQ-022 A master that requests again after release shall not be re-granted while any other eligible requester exists.

Reset
REQ-023 A rising edge with HRESET=1 shall force HGRANTx to one-hot DEFAULT_MASTER.
REQ-024 The same reset edge shall force HMASTER=DEFAULT_MASTER, HMASTLOCK=0, the round-robin pointer to DEFAULT_MASTER, and all split masks to 0.
REQ-025 Reset shall take priority over every other event, including mid-lock and mid-split; no lock or mask state survives it.

Configuration
REQ-026 Macro AHB_ARB_SPLIT_EN, when defined, compiles in per-master split masking.
REQ-027 Mask set: an edge with HRESP=2'b11 and HREADY=0 shall set mask[HMASTER]; the next HREADY=1 edge shall move the grant away from that master.
REQ-028 Masked master exclusion: a masked master shall be excluded from arbitration and from lock hold.
REQ-029 Split clears lock: the split shall drop HMASTLOCK on the following HREADY=1 edge.
REQ-030 Mask clear: an edge with HSPLIT[i]=1 shall clear mask[i]; if set and clear coincide on the same index, clear wins.
REQ-031 DEFAULT_MASTER shall never be masked; a SPLIT response issued to it is ignored.
REQ-032 Without AHB_ARB_SPLIT_EN, HSPLIT and HRESP shall be ignored and no mask storage shall exist; all other behaviour is identical.

Verification
REQ-033 Reset, no requests -> HGRANTx=0001, HMASTER=0, HMASTLOCK=0 (NUM_MASTERS=4, DEFAULT_MASTER=0).
REQ-034 HBUSREQx=1111 held, HREADY=1 -> grants rotate 0001->0010->0100->1000->0001 on consecutive edges; HMASTER trails by one edge.
REQ-035 Master 2 holds HLOCKx[2]=HBUSREQx[2]=1 for 5 cycles with all others requesting -> HGRANTx=0100 throughout; HMASTLOCK=1; master 3 granted on the first edge after release.
REQ-036 HREADY=0 for 3 cycles during a request change -> HGRANTx, HMASTER and HMASTLOCK frozen; update on the first HREADY=1 edge.
REQ-037 With AHB_ARB_SPLIT_EN: master 1 receives HRESP=11 with HREADY=0 then HREADY=1 -> grant leaves 1; master 1 is not re-granted while requesting until HSPLIT[1]=1, then granted in turn.
REQ-038 HRESET asserted while master 3 is locked and master 1 is masked -> next edge gives HGRANTx=0001, HMASTLOCK=0, and no mask remaining.
